// File: rtl/iob_split.sv
// IOb native demultiplexer: one master to N followers, selected by the address MSBs.
// Reads to one follower may be pipelined; switching followers waits for all reads to drain.
module iob_split #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N        = 2,
  parameter int unsigned NB       = $clog2(N),
  parameter int unsigned MAX_PEND = 4
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,
  input  logic                  m_avalid_i,
  input  logic [ADDR_W-1:0]     m_addr_i,
  input  logic [DATA_W-1:0]     m_wdata_i,
  input  logic [DATA_W/8-1:0]   m_wstrb_i,
  output logic [DATA_W-1:0]     m_rdata_o,
  output logic                  m_rvalid_o,
  output logic                  m_ready_o,
  output logic [N-1:0]          f_avalid_o,
  output logic [ADDR_W-1:0]     f_addr_o,
  output logic [DATA_W-1:0]     f_wdata_o,
  output logic [DATA_W/8-1:0]   f_wstrb_o,
  input  logic [N*DATA_W-1:0]   f_rdata_i,
  input  logic [N-1:0]          f_rvalid_i,
  input  logic [N-1:0]          f_ready_i
);

  localparam int unsigned CW = $clog2(MAX_PEND + 1);
  localparam int unsigned SW = NB + 1;

  logic [SW-1:0] sel;
  logic          mapped;
  logic          is_read;
  logic          stall;
  logic          ready_sel;
  logic          accept;
  logic          rd_accept;

  logic [SW-1:0] pend_sel_q, pend_sel_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic          err_rvalid_q, err_rvalid_d;

  assign sel     = {1'b0, m_addr_i[ADDR_W-1 -: NB]};
  assign mapped  = (sel < SW'(N));
  assign is_read = (m_wstrb_i == '0);

  assign stall = (pend_cnt_q != '0) &&
                 ((sel != pend_sel_q) || (pend_cnt_q == CW'(MAX_PEND)));

  assign f_addr_o  = m_addr_i;
  assign f_wdata_o = m_wdata_i;
  assign f_wstrb_o = m_wstrb_i;

  // Unmapped selects fall through to the always-ready error responder.
  always_comb begin
    ready_sel = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      if (sel == SW'(k)) ready_sel = f_ready_i[k];
    end
  end

  always_comb begin
    f_avalid_o = '0;
    for (int k = 0; k < int'(N); k++) begin
      f_avalid_o[k] = m_avalid_i && !stall && (sel == SW'(k));
    end
  end

  assign m_ready_o = stall ? 1'b0 : (mapped ? ready_sel : 1'b1);
  assign accept    = m_avalid_i && m_ready_o;
  assign rd_accept = accept && is_read;

  always_comb begin
    m_rvalid_o = 1'b0;
    m_rdata_o  = '0;
    if (pend_sel_q == SW'(N)) begin
      m_rvalid_o = err_rvalid_q;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (pend_sel_q == SW'(k)) begin
          m_rvalid_o = (pend_cnt_q != '0) && f_rvalid_i[k];
          m_rdata_o  = f_rdata_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    pend_sel_d   = pend_sel_q;
    pend_cnt_d   = pend_cnt_q;
    err_rvalid_d = rd_accept && !mapped;
    if (rd_accept) pend_sel_d = sel;
    if (rd_accept && !m_rvalid_o) begin
      pend_cnt_d = pend_cnt_q + CW'(1);
    end else if (m_rvalid_o && !rd_accept) begin
      pend_cnt_d = pend_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pend_sel_q   <= '0;
      pend_cnt_q   <= '0;
      err_rvalid_q <= 1'b0;
    end else if (cke_i) begin
      pend_sel_q   <= pend_sel_d;
      pend_cnt_q   <= pend_cnt_d;
      err_rvalid_q <= err_rvalid_d;
    end
  end

endmodule

// File: tb/tb_iob_split.sv
// Bench for iob_split: directed scenarios then random traffic, all checked against a
// queue-based model of outstanding reads.
module tb_iob_split;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned N        = 3;
  localparam int unsigned NB       = 2;
  localparam int unsigned MAX_PEND = 4;

  logic                clk = 1'b0;
  logic                cke;
  logic                arst;
  logic                m_avalid;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_rvalid;
  logic                m_ready;
  logic [N-1:0]        f_avalid;
  logic [ADDR_W-1:0]   f_addr;
  logic [DATA_W-1:0]   f_wdata;
  logic [DATA_W/8-1:0] f_wstrb;
  logic [N*DATA_W-1:0] f_rdata;
  logic [N-1:0]        f_rvalid;
  logic [N-1:0]        f_ready;

  iob_split #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N(N), .NB(NB), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
    .m_rdata_o(m_rdata), .m_rvalid_o(m_rvalid), .m_ready_o(m_ready),
    .f_avalid_o(f_avalid), .f_addr_o(f_addr), .f_wdata_o(f_wdata), .f_wstrb_o(f_wstrb),
    .f_rdata_i(f_rdata), .f_rvalid_i(f_rvalid), .f_ready_i(f_ready)
  );

  always #5 clk = ~clk;

  // Model: targets of outstanding reads in order (3 = error responder).
  int q[$];
  bit err_due;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] a, input logic [3:0] ws);
    m_avalid = av;
    m_addr   = a;
    m_wstrb  = ws;
    m_wdata  = $urandom;
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic cycle(output bit took);
    int t;
    bit rd, stall, exp_rdy, exp_rv;
    logic [N-1:0] exp_av;
    logic [DATA_W-1:0] exp_rd;
    #2;
    t  = int'(m_addr[7:6]);
    rd = (m_wstrb == '0);
    stall = (q.size() != 0) && ((t != q[0]) || (q.size() == MAX_PEND));
    exp_av = '0;
    if (m_avalid && !stall && t < N) exp_av[t] = 1'b1;
    exp_rdy = stall ? 1'b0 : ((t < N) ? f_ready[t] : 1'b1);
    exp_rv = 1'b0;
    exp_rd = '0;
    if (q.size() != 0) begin
      if (q[0] < N) begin
        exp_rv = f_rvalid[q[0]];
        exp_rd = f_rdata[q[0]*DATA_W +: DATA_W];
      end else begin
        exp_rv = err_due;
      end
    end
    chk("f_avalid", DATA_W'(f_avalid), DATA_W'(exp_av));
    chk("f_addr", DATA_W'(f_addr), DATA_W'(m_addr));
    if (m_avalid) chk("m_ready", DATA_W'(m_ready), DATA_W'(exp_rdy));
    chk("m_rvalid", DATA_W'(m_rvalid), DATA_W'(exp_rv));
    if (exp_rv) chk("m_rdata", m_rdata, exp_rd);
    took = m_avalid && exp_rdy && cke && !arst;
    @(posedge clk);
    if (cke && !arst) begin
      if (exp_rv) void'(q.pop_front());
      if (took && rd) q.push_back(t);
      err_due = took && rd && (t >= N);
    end
    #1;
  endtask

  task automatic step();
    bit dummy;
    cycle(dummy);
  endtask

  initial begin
    bit took;
    bit holding;
    cke = 1'b1; arst = 1'b1; f_ready = '0; f_rvalid = '0;
    f_rdata = {32'h2222_2222, 32'hA5A5_A5A5, 32'h0000_0000};
    drive(1'b0, 8'h00, 4'h0);
    err_due = 1'b0;
    #2;
    chk("rst_f_avalid", DATA_W'(f_avalid), 32'h0);
    chk("rst_m_rvalid", DATA_W'(m_rvalid), 32'h0);
    @(posedge clk); #1; arst = 1'b0;

    // Single read to follower 1, response two cycles later.
    drive(1'b1, 8'h40, 4'h0); f_ready = 3'b010;
    #1 chk("rd1_f_avalid", DATA_W'(f_avalid), 32'h2);
    step();
    drive(1'b0, 8'h40, 4'h0); step();
    f_rvalid = 3'b010;
    #1 chk("rd1_rvalid", DATA_W'(m_rvalid), 32'h1);
    chk("rd1_rdata", m_rdata, 32'hA5A5_A5A5);
    step();
    f_rvalid = '0;

    // Fill to MAX_PEND on follower 0, then one response frees a slot.
    f_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h00, 4'h0);
      #1 chk("fill_ready", DATA_W'(m_ready), 32'h1);
      step();
    end
    #1 chk("full_ready", DATA_W'(m_ready), 32'h0);
    step();
    f_rvalid = 3'b001; f_rdata[31:0] = 32'h1234_5678;
    #1 chk("full_drain_ready", DATA_W'(m_ready), 32'h0);
    step();
    f_rvalid = '0;
    #1 chk("fifth_ready", DATA_W'(m_ready), 32'h1);
    step();
    drive(1'b0, 8'h00, 4'h0); f_rvalid = 3'b001;
    for (int i = 0; i < 4; i++) step();
    f_rvalid = '0;

    // Write to another follower waits until the pending read drains.
    drive(1'b1, 8'h00, 4'h0); step();
    drive(1'b1, 8'h80, 4'hF);
    #1 chk("sw_stall_ready", DATA_W'(m_ready), 32'h0);
    chk("sw_stall_avalid", DATA_W'(f_avalid), 32'h0);
    step();
    f_rvalid = 3'b001;
    #1 chk("sw_drain_ready", DATA_W'(m_ready), 32'h0);
    step();
    f_rvalid = '0;
    #1 chk("sw_go_avalid", DATA_W'(f_avalid), 32'h4);
    step();

    // Unmapped read and write.
    drive(1'b1, 8'hC0, 4'h0);
    #1 chk("err_rd_ready", DATA_W'(m_ready), 32'h1);
    step();
    drive(1'b1, 8'hC4, 4'h3);
    #1 chk("err_rvalid", DATA_W'(m_rvalid), 32'h1);
    chk("err_rdata", m_rdata, 32'h0);
    chk("err_wr_ready", DATA_W'(m_ready), 32'h1);
    step();
    drive(1'b0, 8'h00, 4'h0);
    #1 chk("err_wr_no_rvalid", DATA_W'(m_rvalid), 32'h0);
    step();

    // Spurious follower responses.
    f_rvalid = 3'b100;
    #1 chk("spur_idle", DATA_W'(m_rvalid), 32'h0);
    step();
    f_rvalid = '0; drive(1'b1, 8'h00, 4'h0); step();
    drive(1'b0, 8'h00, 4'h0); f_rvalid = 3'b100;
    #1 chk("spur_pend", DATA_W'(m_rvalid), 32'h0);
    step();
    f_rvalid = 3'b001; step(); f_rvalid = '0;

    // Reset with two reads pending.
    drive(1'b1, 8'h00, 4'h0); step(); step();
    drive(1'b0, 8'h00, 4'h0); arst = 1'b1; q.delete(); err_due = 1'b0;
    step();
    arst = 1'b0; f_rvalid = 3'b001; drive(1'b1, 8'h80, 4'h0);
    #1 chk("post_rst_rvalid", DATA_W'(m_rvalid), 32'h0);
    chk("post_rst_ready", DATA_W'(m_ready), 32'h1);
    step();
    f_rvalid = 3'b100; drive(1'b0, 8'h00, 4'h0); step();
    f_rvalid = '0;

    // Random traffic; requests are held until accepted.
    holding = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!holding) begin
        drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)));
      end
      f_ready  = 3'($urandom);
      f_rvalid = 3'($urandom);
      f_rdata  = {$urandom, $urandom, $urandom};
      cke      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 63) == 0) begin
        arst = 1'b1; q.delete(); err_due = 1'b0;
      end
      cycle(took);
      if (arst) begin
        arst = 1'b0; holding = 1'b0;
      end else begin
        holding = m_avalid && !took;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
